// File: rtl/gate_vector_sequencer.sv
// gate_vector_sequencer
//   Clocked stimulus-and-check stage for a two-input basic_gate block.
//   A start pulse sweeps {a,b} through 00, 01, 10, 11. Each vector is held for
//   SETTLE cycles, then the seven gate outputs y = {y7..y1} are sampled and
//   compared with the expected truth table EXP_TABLE. The sequencer reports
//   pass/fail, a mismatch count and a per-vector fail mask.
//
//   Optional feature macro: GATE_SEQ_CAPTURE_EN
//     When defined, the outputs fail_y and fail_ab are added. They hold the y
//     value and the {a,b} value seen at the first mismatching sample of the
//     sweep.
//
//   Handshake: start is a single-cycle request pulse with no ready signal.
//   It is accepted only in IDLE, which is the cycle where busy=0 and done=0.
//   A start seen in any other state, including the done cycle, is dropped.
//   done pulses high for one cycle when a sweep finishes. pass, err_cnt and
//   fail_mask are valid from done until the next accepted start.
module gate_vector_sequencer #(
  parameter int          SETTLE    = 2,
  parameter logic [27:0] EXP_TABLE = 28'h465AB6C
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [6:0] y,
  output logic       a,
  output logic       b,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_cnt,
  output logic [3:0] fail_mask
`ifdef GATE_SEQ_CAPTURE_EN
  ,
  output logic [6:0] fail_y,
  output logic [1:0] fail_ab
`endif
);

  typedef enum logic [1:0] {
    S_IDLE        = 2'd0,
    S_SETTLE_WAIT = 2'd1,
    S_SAMPLE      = 2'd2,
    S_DONE        = 2'd3
  } state_t;

  // The counter is loaded with SETTLE-1 and the FSM leaves SETTLE_WAIT on the
  // cycle where the counter reads 0. This holds each vector for SETTLE cycles.
  localparam logic [7:0] RELOAD = 8'(SETTLE - 1);

  state_t     state_q, state_d;
  logic [1:0] idx_q, idx_d;
  logic [7:0] cnt_q, cnt_d;
  logic [1:0] ab_q, ab_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       pass_q, pass_d;
  logic [2:0] err_q, err_d;
  logic [3:0] mask_q, mask_d;
`ifdef GATE_SEQ_CAPTURE_EN
  logic [6:0] fail_y_q, fail_y_d;
  logic [1:0] fail_ab_q, fail_ab_d;
`endif

  logic [4:0] exp_base;
  logic [6:0] exp_vec;
  logic       hit;
  logic       mismatch;
  logic [2:0] err_next;

  // Expected-value lookup and compare for the current vector. If y contains X,
  // the if condition takes the else path, so X is counted as a mismatch.
  always_comb begin
    exp_base = 5'(idx_q) * 5'd7;
    exp_vec  = EXP_TABLE[exp_base +: 7];
    hit      = 1'b0;
    if (y == exp_vec) begin
      hit = 1'b1;
    end
    mismatch = ~hit;
    err_next = err_q + {2'b00, mismatch};
  end

  // Next-state and next-output logic for the sweep FSM.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    ab_d      = ab_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    pass_d    = pass_q;
    err_d     = err_q;
    mask_d    = mask_q;
`ifdef GATE_SEQ_CAPTURE_EN
    fail_y_d  = fail_y_q;
    fail_ab_d = fail_ab_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          err_d     = 3'd0;
          mask_d    = 4'd0;
          pass_d    = 1'b0;
          idx_d     = 2'd0;
          ab_d      = 2'b00;
          cnt_d     = RELOAD;
          busy_d    = 1'b1;
`ifdef GATE_SEQ_CAPTURE_EN
          fail_y_d  = 7'd0;
          fail_ab_d = 2'd0;
`endif
          state_d   = S_SETTLE_WAIT;
        end
      end
      S_SETTLE_WAIT: begin
        if (cnt_q == 8'd0) begin
          state_d = S_SAMPLE;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      S_SAMPLE: begin
        if (mismatch) begin
          mask_d[idx_q] = 1'b1;
          err_d         = err_next;
`ifdef GATE_SEQ_CAPTURE_EN
          // Only the first mismatch of a sweep is captured.
          if (err_q == 3'd0) begin
            fail_y_d  = y;
            fail_ab_d = ab_q;
          end
`endif
        end
        if (idx_q != 2'd3) begin
          idx_d   = idx_q + 2'd1;
          ab_d    = idx_q + 2'd1;
          cnt_d   = RELOAD;
          state_d = S_SETTLE_WAIT;
        end else begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          pass_d  = (err_next == 3'd0);
          ab_d    = 2'b00;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      idx_q     <= 2'd0;
      cnt_q     <= 8'd0;
      ab_q      <= 2'b00;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      err_q     <= 3'd0;
      mask_q    <= 4'd0;
`ifdef GATE_SEQ_CAPTURE_EN
      fail_y_q  <= 7'd0;
      fail_ab_q <= 2'd0;
`endif
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      ab_q      <= ab_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      pass_q    <= pass_d;
      err_q     <= err_d;
      mask_q    <= mask_d;
`ifdef GATE_SEQ_CAPTURE_EN
      fail_y_q  <= fail_y_d;
      fail_ab_q <= fail_ab_d;
`endif
    end
  end

  assign a         = ab_q[1];
  assign b         = ab_q[0];
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_cnt   = err_q;
  assign fail_mask = mask_q;
`ifdef GATE_SEQ_CAPTURE_EN
  assign fail_y    = fail_y_q;
  assign fail_ab   = fail_ab_q;
`endif

endmodule
